// File: rtl/debouncer.sv
// Push-button debouncer: synchronises the raw button into clk and moves result
// to the new level only after it has held for STABLE_CYCLES consecutive cycles.
module debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = $clog2(STABLE_CYCLES) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic result
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_result;
  logic                   w_s;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign result = r_result;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], button};
    end
  end

  // Any cycle where s agrees with result restarts the count, so only an
  // unbroken run of STABLE_CYCLES disagreeing samples can flip the output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_result <= 1'b0;
    end else if (w_s == r_result) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt    <= '0;
      r_result <= w_s;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_debouncer.sv
// Directed bench for debouncer with default parameters (2 sync stages, 4 stable cycles).
module tb_debouncer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic button = 1'b0;
  logic result;
  int   checks = 0;
  int   errors = 0;
  logic watch = 1'b0;
  logic saw_high = 1'b0;

  debouncer dut (
    .clk    (clk),
    .reset  (reset),
    .button (button),
    .result (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (watch && result) saw_high = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle_low();
    button = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    for (int k = 0; k < 6; k++) begin
      button = k[0];
      tick();
      checks++;
      if (result !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold_result k=%0d got %b want 0", k, result);
      end
      checks++;
      if (dut.r_cnt !== 3'd0) begin
        errors++;
        $display("FAIL reset_hold_cnt k=%0d got %0d want 0", k, dut.r_cnt);
      end
    end
    button = 1'b0;
    #2 reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (result !== 1'b0) begin
        errors++;
        $display("FAIL reset_release edge=%0d got %b want 0", k, result);
      end
    end
  endtask

  task automatic test_clean_press();
    button = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (result !== (k >= 6)) begin
        errors++;
        $display("FAIL clean_press edge=%0d got %b want %b", k, result, (k >= 6));
      end
    end
    settle_low();
    checks++;
    if (result !== 1'b0) begin
      errors++;
      $display("FAIL clean_press_return got %b want 0", result);
    end
  endtask

  task automatic test_bounce();
    saw_high = 1'b0;
    watch    = 1'b1;
    button = 1'b1; #10;
    button = 1'b0; #15;
    button = 1'b1; #15;
    button = 1'b0; #10;
    button = 1'b1; #25;
    button = 1'b0; #20;
    watch  = 1'b0;
    checks++;
    if (saw_high !== 1'b0) begin
      errors++;
      $display("FAIL bounce_reject got high=%b want 0", saw_high);
    end
    button = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (result !== (k >= 6)) begin
        errors++;
        $display("FAIL bounce_final_hold edge=%0d got %b want %b", k, result, (k >= 6));
      end
    end
  endtask

  task automatic test_release();
    button = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (result !== (k < 6)) begin
        errors++;
        $display("FAIL release edge=%0d got %b want %b", k, result, (k < 6));
      end
    end
    button = 1'b1;
    repeat (8) tick();
    checks++;
    if (result !== 1'b1) begin
      errors++;
      $display("FAIL glitch_setup got %b want 1", result);
    end
    button = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 2) button = 1'b1;
      checks++;
      if (result !== 1'b1) begin
        errors++;
        $display("FAIL glitch_hold edge=%0d got %b want 1", k, result);
      end
      if (k >= 3 && k <= 5) begin
        checks++;
        if (dut.r_cnt !== ((k == 5) ? 3'd0 : 3'(k - 2))) begin
          errors++;
          $display("FAIL glitch_cnt edge=%0d got %0d want %0d", k, dut.r_cnt, (k == 5) ? 0 : k - 2);
        end
      end
    end
    settle_low();
  endtask

  task automatic test_boundary_width();
    button = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 3) button = 1'b0;
      checks++;
      if (result !== 1'b0) begin
        errors++;
        $display("FAIL width3 edge=%0d got %b want 0", k, result);
      end
    end
    button = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 4) button = 1'b0;
      checks++;
      if (result !== (k >= 6 && k <= 9)) begin
        errors++;
        $display("FAIL width4 edge=%0d got %b want %b", k, result, (k >= 6 && k <= 9));
      end
    end
  endtask

  task automatic test_reset_mid_count();
    settle_low();
    button = 1'b1;
    repeat (3) tick();
    checks++;
    if (dut.r_cnt !== 3'd1) begin
      errors++;
      $display("FAIL midcount_pre_cnt got %0d want 1", dut.r_cnt);
    end
    #3 reset = 1'b0;
    #1;
    checks++;
    if (result !== 1'b0) begin
      errors++;
      $display("FAIL midcount_async_result got %b want 0", result);
    end
    checks++;
    if (dut.r_cnt !== 3'd0) begin
      errors++;
      $display("FAIL midcount_async_cnt got %0d want 0", dut.r_cnt);
    end
    checks++;
    if (dut.r_sync !== 2'b00) begin
      errors++;
      $display("FAIL midcount_async_sync got %b want 00", dut.r_sync);
    end
    #2 reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (result !== (k >= 6)) begin
        errors++;
        $display("FAIL midcount_restart edge=%0d got %b want %b", k, result, (k >= 6));
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_boundary_width();
    test_reset_mid_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debouncer.md
Name: debouncer

Overview:
- Filters a noisy, asynchronous mechanical push-button input into a clean, glitch-free level on `result`.
- The raw input is first synchronised into the `clk` domain.
- `result` follows the synchronised level only after it has held steady for a programmable number of consecutive clock cycles.
- Sits between a board-level button pin and user logic; one instance per button.

Parameters:
- SYNC_STAGES, default 2: number of flip-flops in the input synchroniser chain; legal range 2 to 4.
- STABLE_CYCLES, default 4: consecutive cycles the synchronised input must differ from `result` before `result` changes; legal range 2 to 2^20.
- CNT_W, default clog2(STABLE_CYCLES)+1: stability counter width. It is derived from STABLE_CYCLES and must not be overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 forces all state to reset values immediately.
- button  input  1  raw button level; asynchronous to clk and possibly bouncing.
- result  output  1  debounced button level; driven directly from a flip-flop.

Behaviour:
- Interface (already decided): one clock (`clk`); reset (`reset`) is asynchronous and active-low.
- Reset while reset=0, regardless of clk:
  - every synchroniser stage = 0;
  - stability counter = 0;
  - `result` = 0.
- Reset release: after reset returns to 1, operation resumes on the next rising clk edge. Reset may be asserted at any time, including mid-count; the count is discarded.
- Synchroniser:
  - `button` shifts through SYNC_STAGES flops each rising edge.
  - `s` = output of the last stage.
  - No logic may use `button` before the synchroniser.
- Stability counter, evaluated on each rising edge:
  - if s == result: counter <= 0;
  - if s != result and counter < STABLE_CYCLES-1: counter <= counter+1;
  - if s != result and counter == STABLE_CYCLES-1: result <= s and counter <= 0.
- Effect: `result` toggles only after s has differed from it on STABLE_CYCLES consecutive rising edges. Any return of s to the current `result` value restarts the count from 0.
- Latency, from the first rising edge that samples a new stable `button` level to the `result` change: SYNC_STAGES + STABLE_CYCLES - 1 edges. With defaults, `result` updates on the 6th rising edge counting the sampling edge as 1st.
- Symmetry: rising and falling transitions are filtered identically.
- Minimum propagation: a `button` pulse shorter than STABLE_CYCLES clock periods (after synchronisation) never reaches `result`.
- `result` changes at most once per STABLE_CYCLES cycles.
- Counter saturation: the counter never exceeds STABLE_CYCLES-1 and never wraps.
- Glitch-free output: `result` is a registered output with no combinational path from `button` or `reset` other than the asynchronous clear.

Test Plan (defaults, 10 ns clk):
1. Reset: hold reset=0 with button toggling -> result=0 throughout and counter=0; release reset with button=0 -> result stays 0.
2. Clean press: button 0->1 held 200 ns -> result rises exactly on the 6th rising edge after button is first sampled and stays 1.
3. Bounce rejection: button pulses 1 for 10, 15 and 25 ns separated by 0 gaps of 10–25 ns -> result stays 0. Final hold of 1 for ≥60 ns -> result goes 1 after 6 edges of stable high.
4. Boundary width: a pulse exactly 3 cycles wide (synchronised) -> result unchanged. A pulse exactly 4 cycles wide -> result goes 1, then returns to 0 after 4 further stable-low cycles.
5. Release: with result=1, button 1->0 held -> result falls after 6 edges. A 2-cycle low glitch during the high hold -> result stays 1 and the counter restarts at 0.
6. Reset mid-count: button high for 3 cycles, then assert reset=0 asynchronously between clock edges -> result=0 and counter=0 immediately. After release with button still high -> the full 6-edge latency restarts from scratch.
